// File: rtl/timer_pkg.sv
// Shared types, widths and preset-clamp helpers for the mm:ss countdown timer.
// Optional build macro used by timer_ctrl: TIMER_CTRL_AUTORELOAD_EN.
package timer_pkg;

  localparam int unsigned MIN_W        = 7;
  localparam int unsigned SEC_W        = 6;
  localparam int unsigned MAX_MIN_DFLT = 99;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_t;

  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] s);
    return (s > SEC_MAX) ? SEC_MAX : s;
  endfunction

  function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] m,
                                                 input logic [MIN_W-1:0] max_m);
    return (m > max_m) ? max_m : m;
  endfunction

endpackage

// File: rtl/timer_ctrl_tick_gen.sv
// Gated prescaler: one-cycle tick when the count reaches CLOCK_FREQ-1 while enabled.
// The count freezes while en is low, so the sub-second phase survives a pause.
module tick_gen #(
  parameter int unsigned CLOCK_FREQ = 25000000
) (
  input  logic clk,
  input  logic rst_b,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned      CNT_W    = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCK_FREQ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_ctrl.sv
// mm:ss countdown controller: start/pause/clear FSM around a gated 1 Hz prescaler.
// Define TIMER_CTRL_AUTORELOAD_EN to reload the latched preset at 00:00 instead of entering DONE.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 25000000,
  parameter int unsigned MAX_MIN    = MAX_MIN_DFLT
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [MIN_W-1:0] load_min,
  input  logic [SEC_W-1:0] load_sec,
  output logic [MIN_W-1:0] cur_min,
  output logic [SEC_W-1:0] cur_sec,
  output logic             running,
  output logic             paused,
  output logic             alarm,
  output logic             done_pulse,
  output logic [1:0]       state
);

  localparam logic [MIN_W-1:0] MAX_MIN_L = MIN_W'(MAX_MIN);

  timer_state_t     state_q, state_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             done_q, done_d;
`ifdef TIMER_CTRL_AUTORELOAD_EN
  logic [MIN_W-1:0] pmin_q, pmin_d;
  logic [SEC_W-1:0] psec_q, psec_d;
`endif

  logic             tick, tg_en, tg_clr;
  logic [MIN_W-1:0] ld_min, dec_min;
  logic [SEC_W-1:0] ld_sec, dec_sec;
  logic             ld_zero, dec_zero, idle_or_done;

  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);

  // Enable/clear are decoded straight from state and inputs so a pause or clear
  // suppresses a coincident tick without a combinational loop through the FSM.
  assign tg_en  = (state_q == RUN) && !clear && !pause;
  assign tg_clr = clear || (start && !pause && idle_or_done);

  tick_gen #(
    .CLOCK_FREQ(CLOCK_FREQ)
  ) u_tick_gen (
    .clk  (clk),
    .rst_b(rst_b),
    .en   (tg_en),
    .clr  (tg_clr),
    .tick (tick)
  );

  assign ld_min   = clamp_min(load_min, MAX_MIN_L);
  assign ld_sec   = clamp_sec(load_sec);
  assign ld_zero  = (ld_min == '0) && (ld_sec == '0);
  assign dec_sec  = (sec_q != '0) ? sec_q - SEC_W'(1) : SEC_MAX;
  assign dec_min  = (sec_q != '0) ? min_q : min_q - MIN_W'(1);
  assign dec_zero = (dec_min == '0) && (dec_sec == '0);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    done_d  = 1'b0;
`ifdef TIMER_CTRL_AUTORELOAD_EN
    pmin_d  = pmin_q;
    psec_d  = psec_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (clear) begin
          state_d = IDLE;
          min_d   = '0;
          sec_d   = '0;
        end else if (!pause && start) begin
`ifdef TIMER_CTRL_AUTORELOAD_EN
          pmin_d = ld_min;
          psec_d = ld_sec;
`endif
          if (ld_zero) begin
            state_d = DONE;
            done_d  = 1'b1;
            min_d   = '0;
            sec_d   = '0;
          end else begin
            state_d = RUN;
            min_d   = ld_min;
            sec_d   = ld_sec;
          end
        end
      end
      RUN: begin
        if (clear) begin
          state_d = IDLE;
          min_d   = '0;
          sec_d   = '0;
        end else if (pause) begin
          state_d = PAUSED;
        end else if (tick) begin
          if (dec_zero) begin
            done_d = 1'b1;
`ifdef TIMER_CTRL_AUTORELOAD_EN
            min_d  = pmin_q;
            sec_d  = psec_q;
`else
            state_d = DONE;
            min_d   = '0;
            sec_d   = '0;
`endif
          end else begin
            min_d = dec_min;
            sec_d = dec_sec;
          end
        end
      end
      PAUSED: begin
        if (clear) begin
          state_d = IDLE;
          min_d   = '0;
          sec_d   = '0;
        end else if (!pause && start) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      min_q   <= '0;
      sec_q   <= '0;
      done_q  <= 1'b0;
`ifdef TIMER_CTRL_AUTORELOAD_EN
      pmin_q  <= '0;
      psec_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      done_q  <= done_d;
`ifdef TIMER_CTRL_AUTORELOAD_EN
      pmin_q  <= pmin_d;
      psec_q  <= psec_d;
`endif
    end
  end

  assign cur_min    = min_q;
  assign cur_sec    = sec_q;
  assign done_pulse = done_q;
  assign state      = state_q;
  assign running    = (state_q == RUN);
  assign paused     = (state_q == PAUSED);
  assign alarm      = (state_q == DONE);

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with CLOCK_FREQ=4 (one decrement every 4 RUN cycles).
// Expectations follow TIMER_CTRL_AUTORELOAD_EN when the macro is defined.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       start, pause, clear;
  logic [6:0] load_min;
  logic [5:0] load_sec;
  logic [6:0] cur_min;
  logic [5:0] cur_sec;
  logic       running, paused, alarm, done_pulse;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  timer_ctrl #(
    .CLOCK_FREQ(4),
    .MAX_MIN   (99)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .pause     (pause),
    .clear     (clear),
    .load_min  (load_min),
    .load_sec  (load_sec),
    .cur_min   (cur_min),
    .cur_sec   (cur_sec),
    .running   (running),
    .paused    (paused),
    .alarm     (alarm),
    .done_pulse(done_pulse),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1; next(1); start = 1'b0;
  endtask

  task automatic pulse_pause;
    pause = 1'b1; next(1); pause = 1'b0;
  endtask

  task automatic pulse_clear;
    clear = 1'b1; next(1); clear = 1'b0;
  endtask

  initial begin
    rst_b = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
    load_min = '0; load_sec = '0;
    #12;
    chk("rst_state", state, 0);
    chk("rst_min", cur_min, 0);
    chk("rst_sec", cur_sec, 0);
    chk("rst_flags", {running, paused, alarm, done_pulse}, 0);
    next(1);
    rst_b = 1'b1;
    next(1);

    // countdown 0:02
    load_min = 7'd0; load_sec = 6'd2;
    pulse_start;
    chk("cd_state", state, 1);
    chk("cd_running", running, 1);
    chk("cd_sec0", cur_sec, 2);
    next(3); chk("cd_edge3", cur_sec, 2);
    next(1); chk("cd_edge4", cur_sec, 1);
    next(3); chk("cd_edge7", cur_sec, 1);
    next(1);
    chk("cd_done_pulse", done_pulse, 1);
`ifdef TIMER_CTRL_AUTORELOAD_EN
    chk("cd_ar_state", state, 1);
    chk("cd_ar_sec", cur_sec, 2);
    chk("cd_ar_alarm", alarm, 0);
`else
    chk("cd_state_done", state, 3);
    chk("cd_alarm", alarm, 1);
    chk("cd_sec_end", cur_sec, 0);
`endif
    next(1);
    chk("cd_pulse_one_cycle", done_pulse, 0);
    pulse_clear;
    chk("cd_cleared", state, 0);

    // minute borrow 1:00
    load_min = 7'd1; load_sec = 6'd0;
    pulse_start;
    next(4);
    chk("borrow_min", cur_min, 0);
    chk("borrow_sec", cur_sec, 59);
    pulse_clear;
    chk("clr_state", state, 0);
    chk("clr_min", cur_min, 0);
    chk("clr_sec", cur_sec, 0);

    // pause / resume 0:05
    load_min = 7'd0; load_sec = 6'd5;
    pulse_start;
    next(2);
    pulse_pause;
    chk("pause_state", state, 2);
    chk("pause_flag", paused, 1);
    next(20);
    chk("pause_hold_sec", cur_sec, 5);
    chk("pause_hold_state", state, 2);
    pulse_start;
    chk("resume_state", state, 1);
    next(1); chk("resume_edge1", cur_sec, 5);
    next(1); chk("resume_edge2", cur_sec, 4);
    next(3);
    pulse_pause;
    chk("tick_pause_state", state, 2);
    chk("tick_pause_sec", cur_sec, 4);
    pulse_start;
    chk("tick_resume_sec", cur_sec, 4);
    next(1); chk("tick_resume_dec", cur_sec, 3);

    clear = 1'b1; pause = 1'b1;
    next(1);
    clear = 1'b0; pause = 1'b0;
    chk("prio_state", state, 0);
    chk("prio_cur", {cur_min, cur_sec}, 0);
    chk("prio_running", running, 0);

    // zero preset and clamp
    load_min = 7'd0; load_sec = 6'd0;
    pulse_start;
    chk("zero_state", state, 3);
    chk("zero_pulse", done_pulse, 1);
    chk("zero_alarm", alarm, 1);
    next(1); chk("zero_pulse_off", done_pulse, 0);
    load_min = 7'd120; load_sec = 6'd63;
    pulse_start;
    chk("clamp_state", state, 1);
    chk("clamp_min", cur_min, 99);
    chk("clamp_sec", cur_sec, 59);
    pulse_start;
    chk("run_start_ignored", {state, cur_min, cur_sec}, {2'd1, 7'd99, 6'd59});

    // asynchronous reset mid-run
    rst_b = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_cur", {cur_min, cur_sec}, 0);
    chk("arst_flags", {running, paused, alarm, done_pulse}, 0);
    next(1);
    rst_b = 1'b1;
    next(1);

    // 0:01 expiry (reload or DONE)
    load_min = 7'd0; load_sec = 6'd1;
    pulse_start;
    next(3); chk("one_pre", cur_sec, 1);
    next(1);
    chk("one_pulse", done_pulse, 1);
`ifdef TIMER_CTRL_AUTORELOAD_EN
    chk("one_ar_state", state, 1);
    chk("one_ar_running", running, 1);
    chk("one_ar_alarm", alarm, 0);
    chk("one_ar_sec", cur_sec, 1);
`else
    chk("one_state", state, 3);
    chk("one_alarm", alarm, 1);
`endif
    pulse_clear;
    pulse_pause;
    chk("idle_pause_noop", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Countdown-timer controller (mm:ss) that sequences the timer's 1 Hz time base.
- Contains its own gated prescaler, so counting can be started, paused, resumed and cleared without losing the sub-second phase.
- Sits between the user-control inputs (start/pause/clear pulses, preset value) and the display/alarm logic.
- Outputs the current minutes/seconds, status flags and a one-cycle done pulse.

Parameters:
- CLOCK_FREQ, 25000000: clk cycles per one-second tick; must be >= 2.
- MAX_MIN, 99: largest minutes value accepted; must be <= 127.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle start/resume request.
- pause  in  1  one-cycle pause request.
- clear  in  1  one-cycle abort/clear request.
- load_min  in  7  preset minutes, binary.
- load_sec  in  6  preset seconds, binary.
- cur_min  out  7  current minutes.
- cur_sec  out  6  current seconds.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSED.
- alarm  out  1  high in DONE.
- done_pulse  out  1  one-cycle pulse on reaching 00:00.
- state  out  2  FSM state encoding.

Behaviour:
- Reset (rst_b low, asynchronous):
  - state=IDLE; cur_min=0, cur_sec=0, prescaler=0.
  - running=0, paused=0, alarm=0, done_pulse=0.
- States and encodings: IDLE=0, RUN=1, PAUSED=2, DONE=3.
- Input priority each cycle: clear > pause > start > tick.
- Preset clamping at start: load_sec>59 is taken as 59; load_min>MAX_MIN is taken as MAX_MIN. The clamped values are latched into preset registers.
- IDLE:
  - start with clamped preset non-zero: load cur_* from preset, clear prescaler, go to RUN on the next edge.
  - start with preset 00:00: go directly to DONE; done_pulse=1 on that edge.
  - pause and clear: no effect beyond staying in IDLE.
- RUN:
  - Prescaler increments every cycle. When it equals CLOCK_FREQ-1, tick=1 and the prescaler wraps to 0.
  - First decrement therefore lands on the CLOCK_FREQ-th edge after entry to RUN.
  - On tick: if cur_sec>0, cur_sec-1; else cur_sec=59 and cur_min-1.
  - If the decrement yields 00:00: go to DONE, done_pulse=1 for that single cycle.
  - pause: go to PAUSED; prescaler and cur_* hold.
  - clear: go to IDLE; cur_*=0, prescaler=0.
  - start: ignored.
  - A pause or clear in the same cycle as a tick wins, and that tick's decrement is discarded.
- PAUSED:
  - Prescaler frozen.
  - start: back to RUN; prescaler resumes from its held value, so sub-second phase is preserved.
  - clear: go to IDLE.
  - pause: ignored.
- DONE:
  - alarm=1 and cur_*=0 are held.
  - clear: go to IDLE.
  - start: reload from the current load_* (clamped) and go to RUN, or back to DONE if the preset is 00:00.
- Output timing: all outputs are registered; status flags follow the state with no combinational input-to-output path.
- Widths: prescaler is $clog2(CLOCK_FREQ) bits; no arithmetic wraps below 0 because 00:00 always exits RUN.

Optional Feature:
- Macro: TIMER_CTRL_AUTORELOAD_EN.
- Defined: on reaching 00:00 in RUN:
  - done_pulse=1 for one cycle.
  - cur_* reload from the latched preset and the block stays in RUN.
  - Prescaler continues without a gap; alarm is never set from RUN.
- Undefined: transition to DONE as described in Behaviour.

Decomposition:
- Shared package timer_pkg holds:
  - state enum typedef (IDLE/RUN/PAUSED/DONE, 2 bits);
  - constants SEC_MAX=59 and default MAX_MIN=99;
  - min/sec width localparams (7/6).
- One sub-module, tick_gen (parameter CLOCK_FREQ; inputs clk, rst_b, en, clr; output tick):
  - gated prescaler, one-cycle tick when count==CLOCK_FREQ-1 while en=1;
  - clr synchronously zeroes the count.
- timer_ctrl instantiates tick_gen and contains the FSM and the mm:ss counters.

Test Plan (CLOCK_FREQ=4):
- Countdown to done: load 0:02, start → cur_sec=1 on 4th edge after RUN entry, 0 on 8th → done_pulse=1 for one cycle, alarm=1, state=3.
- Minute borrow: load 1:00, start → after one tick cur_min=0, cur_sec=59.
- Pause/resume: load 0:05; pause after 2 RUN cycles; hold 20 cycles with cur_sec=5 unchanged; start → next decrement after 2 more RUN cycles.
- Priority: clear and pause in the same cycle during RUN → IDLE, cur_*=0. Tick coincident with pause → no decrement.
- Zero and clamp: start with 0:00 → DONE next edge, done_pulse=1. load_sec=63, load_min=120 → cur=99:59.
- Reset mid-run: assert rst_b low asynchronously in RUN → all outputs 0 immediately, state=IDLE. With TIMER_CTRL_AUTORELOAD_EN, 0:01 reloads to 0:01 with running=1 and alarm=0.
